uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 153 +++++++++++++++
 tb/tb_uart_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: a 4-entry byte FIFO feeding an 8N1 serializer.
// Each line bit lasts BPS clk cycles. Queued bytes go out back to back.
// The bit after a stop bit is the next start bit, with no idle gap.
module uart_tx #(
   parameter int BPS = 5208
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] din,
   input  logic       din_vld,
   output logic       din_rdy,
   output logic       dout,
   output logic       busy,
   output logic       tx_done
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [15:0] BAUD_LAST = 16'(BPS - 1);
   localparam logic [15:0] BAUD_PRE  = 16'(BPS - 2);

   state_t      state;
   logic [15:0] baud_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift_reg;

   logic [7:0]  fifo_mem [4];
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic [2:0]  count;
   logic [2:0]  count_next;

   logic        push;
   logic        pop;
   logic        baud_last;
   logic        frame_end;
   logic        idle_next;

   assign din_rdy   = (count != 3'd4);
   assign push      = din_vld && din_rdy;
   assign baud_last = (baud_cnt == BAUD_LAST);
   assign frame_end = (state == STOP) && baud_last;
   // The serializer takes a byte when it is idle, or when a stop bit ends.
   assign pop       = (count != 3'd0) && ((state == IDLE) || frame_end);
   // The FSM sits in IDLE after this edge only if no byte is popped.
   assign idle_next = ((state == IDLE) || frame_end) && !pop;

   // Next occupancy. A push and a pop on the same edge cancel out.
   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + 3'd1;
      end else if (pop && !push) begin
         count_next = count - 3'd1;
      end
   end

   // FIFO pointers and occupancy. The 2-bit pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         count <= count_next;
      end
   end

   // FIFO storage. Only the pointers need a reset; the contents do not.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= din;
      end
   end

   // Frame sequencer. It also produces the registered line, busy and done outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         dout      <= 1'b1;
         tx_done   <= 1'b0;
         busy      <= 1'b0;
         baud_cnt  <= 16'd0;
         bit_idx   <= 3'd0;
         shift_reg <= 8'd0;
      end else begin
         tx_done <= (state == STOP) && (baud_cnt == BAUD_PRE);
         busy    <= !idle_next || (count_next != 3'd0);
         case (state)
            IDLE: begin
               dout     <= 1'b1;
               baud_cnt <= 16'd0;
               if (pop) begin
                  shift_reg <= fifo_mem[rd_ptr];
                  dout      <= 1'b0;
                  state     <= START;
               end
            end
            START: begin
               if (baud_last) begin
                  baud_cnt <= 16'd0;
                  bit_idx  <= 3'd0;
                  dout     <= shift_reg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            DATA: begin
               if (baud_last) begin
                  baud_cnt  <= 16'd0;
                  bit_idx   <= bit_idx + 3'd1;
                  shift_reg <= {1'b0, shift_reg[7:1]};
                  if (bit_idx == 3'd7) begin
                     dout  <= 1'b1;
                     state <= STOP;
                  end else begin
                     dout <= shift_reg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            STOP: begin
               if (baud_last) begin
                  baud_cnt <= 16'd0;
                  if (pop) begin
                     shift_reg <= fifo_mem[rd_ptr];
                     dout      <= 1'b0;
                     state     <= START;
                  end else begin
                     dout  <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            default: begin
               state <= IDLE;
               dout  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx.
// Two instances run side by side: one with BPS=16 and one with BPS=4.
// Single frames are checked cycle by cycle against hand-written line patterns.
// Bursts, back-pressure, reset abort and random traffic are checked
// with a mid-bit sampling receiver.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] din16, din4;
   logic       vld16, vld4;
   logic       rdy16, rdy4, dout16, dout4, busy16, busy4, done16, done4;

   always #5 clk = ~clk;

   uart_tx #(.BPS(16)) u16 (
      .clk(clk), .rst_n(rst_n), .din(din16), .din_vld(vld16), .din_rdy(rdy16),
      .dout(dout16), .busy(busy16), .tx_done(done16)
   );

   uart_tx #(.BPS(4)) u4 (
      .clk(clk), .rst_n(rst_n), .din(din4), .din_vld(vld4), .din_rdy(rdy4),
      .dout(dout4), .busy(busy4), .tx_done(done4)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [7:0] rx_q[$];
   int         rx_start_q[$];
   bit         rx_stop_q[$];
   int         done_cyc_q[$];

   typedef struct {
      bit         sel4;
      logic [7:0] data;
      logic [9:0] line;
   } vec_t;

   vec_t vecs[7];

   // Edge counter. Samples taken 1ns after an edge see that edge's number.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit s4, input logic [7:0] data, output int acc_cyc,
                                output bit ok, output bit first_rdy);
      bit rdy;
      ok = 1'b0;
      acc_cyc = -1;
      first_rdy = 1'b0;
      @(negedge clk);
      if (s4) begin din4 = data; vld4 = 1'b1; end
      else    begin din16 = data; vld16 = 1'b1; end
      for (int i = 0; i < 1000 && !ok; i++) begin
         rdy = s4 ? rdy4 : rdy16;
         if (i == 0) first_rdy = rdy;
         @(posedge clk); #1;
         if (rdy) begin
            ok = 1'b1;
            acc_cyc = cyc;
         end else begin
            @(negedge clk);
         end
      end
      vld4 = 1'b0;
      vld16 = 1'b0;
      checkOutput($sformatf("accept %0h", data), ok, 1);
   endtask

   task automatic waitIdle16();
      for (int i = 0; i < 4000 && busy16 !== 1'b0; i++) begin
         @(posedge clk); #1;
      end
      checkOutput("drain busy", busy16, 0);
   endtask

   task automatic clearQueues();
      rx_q.delete();
      rx_start_q.delete();
      rx_stop_q.delete();
      done_cyc_q.delete();
   endtask

   // Mid-bit sampling receiver on the BPS=16 line. It records bytes,
   // start-edge cycles and stop-bit values.
   initial begin
      logic [7:0] b;
      int         s;
      forever begin
         @(posedge clk); #1;
         if (rst_n === 1'b1 && dout16 === 1'b0) begin
            s = cyc;
            repeat (8) @(posedge clk);
            for (int k = 0; k < 8; k++) begin
               repeat (16) @(posedge clk);
               #1 b[k] = dout16;
            end
            repeat (16) @(posedge clk);
            #1;
            rx_stop_q.push_back(dout16);
            rx_q.push_back(b);
            rx_start_q.push_back(s);
         end
      end
   end

   // Records the edge after which tx_done is seen high on the BPS=16 instance.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (done16 === 1'b1) done_cyc_q.push_back(cyc);
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [255:0] obs_d, exp_d, obs_t, exp_t, obs_b, exp_b;
      logic [7:0]   burst[6];
      logic [7:0]   exp_q[$];
      logic [7:0]   rb;
      int           acc[6];
      bit           fr[6];
      bit           ok;
      int           bps, frame, s0, low_seen, done_seen, busy_seen, bad_stop;

      vecs[0] = '{1'b0, 8'h55, 10'b1010101010};
      vecs[1] = '{1'b0, 8'hA3, 10'b1101000110};
      vecs[2] = '{1'b0, 8'hFF, 10'b1111111110};
      vecs[3] = '{1'b0, 8'h00, 10'b1000000000};
      vecs[4] = '{1'b0, 8'h81, 10'b1100000010};
      vecs[5] = '{1'b1, 8'h00, 10'b1000000000};
      vecs[6] = '{1'b1, 8'h3C, 10'b1001111000};

      din16 = 8'h00; din4 = 8'h00; vld16 = 1'b0; vld4 = 1'b0;
      rst_n = 1'b0;

      // ---- reset state ----
      #13;
      checkOutput("reset dout", dout16, 1);
      checkOutput("reset busy", busy16, 0);
      checkOutput("reset tx_done", done16, 0);
      checkOutput("reset din_rdy", rdy16, 1);
      checkOutput("reset dout bps4", dout4, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("post-reset din_rdy", rdy16, 1);
      checkOutput("post-reset dout", dout16, 1);

      // ---- single frames, cycle-accurate against the table ----
      for (int i = 0; i < 7; i++) begin
         bps = vecs[i].sel4 ? 4 : 16;
         frame = 10 * bps;
         obs_d = '0; exp_d = '0; obs_t = '0; exp_t = '0; obs_b = '0; exp_b = '0;
         applyStimulus(vecs[i].sel4, vecs[i].data, acc[0], ok, fr[0]);
         for (int j = 0; j <= frame + 4; j++) begin
            if (j > 0) begin
               @(posedge clk); #1;
            end
            obs_d[j] = vecs[i].sel4 ? dout4 : dout16;
            obs_t[j] = vecs[i].sel4 ? done4 : done16;
            obs_b[j] = vecs[i].sel4 ? busy4 : busy16;
            exp_d[j] = (j >= 1 && j <= frame) ? vecs[i].line[(j - 1) / bps] : 1'b1;
            exp_t[j] = (j == frame);
            exp_b[j] = (j <= frame);
         end
         checkOutput($sformatf("vec%0d dout wave", i), obs_d, exp_d);
         checkOutput($sformatf("vec%0d tx_done wave", i), obs_t, exp_t);
         checkOutput($sformatf("vec%0d busy wave", i), obs_b, exp_b);
      end

      // ---- burst of six with back-pressure ----
      clearQueues();
      burst[0] = 8'hA3; burst[1] = 8'h0F; burst[2] = 8'hFF;
      burst[3] = 8'h00; burst[4] = 8'h81; burst[5] = 8'h3C;
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, burst[i], acc[i], ok, fr[i]);
      for (int i = 1; i < 5; i++) checkOutput($sformatf("burst accept slot %0d", i), acc[i] - acc[0], i);
      checkOutput("burst 6th din_rdy", fr[5], 0);
      checkOutput("burst tx_done seen", done_cyc_q.size() > 0, 1);
      if (done_cyc_q.size() > 0) checkOutput("burst 6th accept edge", acc[5], done_cyc_q[0] + 2);
      waitIdle16();
      checkOutput("burst frame count", rx_q.size(), 6);
      if (rx_q.size() == 6) begin
         checkOutput("burst first start", rx_start_q[0], acc[0] + 1);
         for (int i = 0; i < 6; i++) checkOutput($sformatf("burst byte %0d", i), rx_q[i], burst[i]);
         for (int i = 1; i < 6; i++) checkOutput($sformatf("burst gap %0d", i), rx_start_q[i] - rx_start_q[i-1], 160);
      end

      // ---- push and pop on the same edge with three queued ----
      clearQueues();
      burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
      burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, burst[i], acc[i], ok, fr[i]);
      for (int i = 0; i < 400 && done16 !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      checkOutput("pop-edge tx_done", done16, 1);
      checkOutput("pop-edge rdy before", rdy16, 1);
      din16 = burst[4]; vld16 = 1'b1;
      @(posedge clk); #1;
      checkOutput("pop-edge rdy after (count 3)", rdy16, 1);
      din16 = burst[5];
      @(posedge clk); #1;
      vld16 = 1'b0;
      checkOutput("pop-edge rdy full (count 4)", rdy16, 0);
      waitIdle16();
      checkOutput("pop-edge frame count", rx_q.size(), 6);
      if (rx_q.size() == 6)
         for (int i = 0; i < 6; i++) checkOutput($sformatf("pop-edge byte %0d", i), rx_q[i], burst[i]);

      // ---- reset in the middle of a frame ----
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'hC0 + 8'(i), acc[i], ok, fr[i]);
      s0 = acc[0] + 1;
      for (int i = 0; i < 300 && cyc < s0 + 50; i++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort dout", dout16, 1);
      checkOutput("abort busy", busy16, 0);
      checkOutput("abort din_rdy", rdy16, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      low_seen = 0; done_seen = 0; busy_seen = 0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         if (dout16 !== 1'b1) low_seen++;
         if (done16 !== 1'b0) done_seen++;
         if (busy16 !== 1'b0) busy_seen++;
      end
      checkOutput("after abort dout low cycles", low_seen, 0);
      checkOutput("after abort tx_done cycles", done_seen, 0);
      checkOutput("after abort busy cycles", busy_seen, 0);

      // ---- random bytes with random gaps, din scrambled after accept ----
      clearQueues();
      for (int i = 0; i < 10; i++) begin
         repeat ($urandom_range(0, 40)) @(posedge clk);
         rb = 8'($urandom);
         applyStimulus(1'b0, rb, acc[0], ok, fr[0]);
         if (ok) exp_q.push_back(rb);
         din16 = 8'($urandom);
      end
      waitIdle16();
      checkOutput("random frame count", rx_q.size(), exp_q.size());
      if (rx_q.size() == exp_q.size()) begin
         bad_stop = 0;
         for (int i = 0; i < exp_q.size(); i++) begin
            checkOutput($sformatf("random byte %0d", i), rx_q[i], exp_q[i]);
            if (rx_stop_q[i] !== 1'b1) bad_stop++;
         end
         checkOutput("random bad stop bits", bad_stop, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
